// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the cache-to-memory bus.
//   c1_cmd_t : CPU-to-cache command encoding (shared with the cache)
//   c2_cmd_t : cache-to-memory command encoding (C2 bus)
//   mem_st_t : mem_ctrl FSM state encoding
package mem_bus_pkg;

  localparam int MEM_SIZE          = 512 * 1024;
  localparam int CACHE_LINE_SIZE   = 16;
  localparam int CACHE_TAG_SIZE    = 10;
  localparam int CACHE_SET_SIZE    = 5;
  localparam int CACHE_OFFSET_SIZE = 4;

  typedef enum logic [1:0] {
    C1_NOP   = 2'd0,
    C1_READ  = 2'd1,
    C1_WRITE = 2'd2
  } c1_cmd_t;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_READ_LINE  = 2'd1,
    C2_WRITE_LINE = 2'd2,
    C2_RESPONSE   = 2'd3
  } c2_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WR_COLLECT = 2'd1,
    ST_WAIT       = 2'd2,
    ST_RESP       = 2'd3
  } mem_st_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_bus_if: C2/A2/D2 bus between cache (master) and memory controller (slave).
//   c2_in/a2_in/d2_in    : cache -> controller command, line address, write beats
//   c2_out/d2_out        : controller -> cache command (NOP/RESPONSE), read beats
//   c2_drive             : controller owns C2/D2 this cycle
interface mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR2_W = 15,
  parameter int DATA2_W = 16
) ();

  c2_cmd_t              c2_in;
  logic [ADDR2_W-1:0]   a2_in;
  logic [DATA2_W-1:0]   d2_in;
  c2_cmd_t              c2_out;
  logic [DATA2_W-1:0]   d2_out;
  logic                 c2_drive;

  modport master (
    output c2_in, a2_in, d2_in,
    input  c2_out, d2_out, c2_drive
  );

  modport slave (
    input  c2_in, a2_in, d2_in,
    output c2_out, d2_out, c2_drive
  );

endinterface

// File: rtl/mem_line_buf.sv
// mem_line_buf: DEPTH x DATA_W register file holding one cache line.
//   CLK               : clock
//   i_we/i_widx/i_wdata : single write port
//   i_ridx/o_rdata    : combinational read port
module mem_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_words [DEPTH];

  // One register per beat; contents need no reset since a reset
  // discards any partially collected line anyway.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DATA_W-1:0] r_word;
    always_ff @(posedge CLK) begin
      if (i_we && (i_widx == IDX_W'(gi))) begin
        r_word <= i_wdata;
      end
    end
    assign w_words[gi] = r_word;
  end

  assign o_rdata = w_words[i_ridx];

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side controller for the C2/A2/D2 bus. Accepts line
// read/write commands in IDLE, moves 8 x 16-bit beats between the bus and a
// synchronous RAM port, and answers with RESPONSE exactly MEM_LATENCY cycles
// after the command was accepted.
//   CLK, RESET  : clock, synchronous active-high reset
//   bus         : C2/A2/D2 slave side
//   busy        : transaction in progress (any state but IDLE)
//   ram_addr/ram_we/ram_wdata : RAM request port
//   ram_rdata   : RAM data, valid one cycle after ram_addr
module mem_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR2_W     = 15,
  parameter int DATA2_W     = 16,
  parameter int LINE_BEATS  = 8,
  parameter int MEM_LATENCY = 100,
  parameter int RAM_AW      = 18
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_bus_if.slave           bus,
  output logic               busy,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic               ram_we,
  output logic [DATA2_W-1:0] ram_wdata,
  input  logic [DATA2_W-1:0] ram_rdata
);

  localparam int CW = $clog2(MEM_LATENCY + 8);
  localparam int BW = $clog2(LINE_BEATS);
  // Low beat bits of MEM_LATENCY, so response beat = (cnt - MEM_LATENCY) mod 8
  localparam logic [BW-1:0] LAT_LO = BW'(MEM_LATENCY % LINE_BEATS);

  mem_st_t            r_state, w_state_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic [ADDR2_W-1:0] r_addr, w_addr_next;
  logic               r_is_write, w_is_write_next;

  logic               w_buf_we;
  logic [BW-1:0]      w_buf_widx, w_buf_ridx;
  logic [DATA2_W-1:0] w_buf_wdata, w_buf_rdata;

  // r_cnt holds (current cycle - T); beat indices derive from its low bits
  logic [BW-1:0] w_beat_cur, w_beat_m1, w_beat_m2, w_beat_resp;
  assign w_beat_cur  = r_cnt[BW-1:0];
  assign w_beat_m1   = r_cnt[BW-1:0] - BW'(1);
  assign w_beat_m2   = r_cnt[BW-1:0] - BW'(2);
  assign w_beat_resp = r_cnt[BW-1:0] - LAT_LO;

  mem_line_buf #(
    .DATA_W (DATA2_W),
    .DEPTH  (LINE_BEATS),
    .IDX_W  (BW)
  ) u_line_buf (
    .CLK     (CLK),
    .i_we    (w_buf_we),
    .i_widx  (w_buf_widx),
    .i_wdata (w_buf_wdata),
    .i_ridx  (w_buf_ridx),
    .o_rdata (w_buf_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_addr     <= w_addr_next;
      r_is_write <= w_is_write_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt + CW'(1);
    w_addr_next     = r_addr;
    w_is_write_next = r_is_write;
    w_buf_we        = 1'b0;
    w_buf_widx      = '0;
    w_buf_wdata     = bus.d2_in;
    w_buf_ridx      = '0;
    ram_addr        = '0;
    ram_we          = 1'b0;
    ram_wdata       = '0;
    bus.c2_out      = C2_NOP;
    bus.d2_out      = '0;
    bus.c2_drive    = 1'b0;
    busy            = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (bus.c2_in == C2_READ_LINE) begin
          w_addr_next     = bus.a2_in;
          w_is_write_next = 1'b0;
          w_cnt_next      = CW'(1);
          w_state_next    = ST_WAIT;
        end else if (bus.c2_in == C2_WRITE_LINE) begin
          w_addr_next     = bus.a2_in;
          w_is_write_next = 1'b1;
          w_cnt_next      = CW'(1);
          w_buf_we        = 1'b1;  // beat 0 rides along with the command
          w_state_next    = ST_WR_COLLECT;
        end
      end

      ST_WR_COLLECT: begin
        // Beats 1..7 arrive back-to-back; c2_in is not looked at here
        w_buf_we   = 1'b1;
        w_buf_widx = w_beat_cur;
        if (r_cnt == CW'(LINE_BEATS - 1)) begin
          w_state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!r_is_write) begin
          // Address beat k at cnt=k+1; RAM answers one cycle later
          if (r_cnt >= CW'(1) && r_cnt <= CW'(LINE_BEATS)) begin
            ram_addr = RAM_AW'({r_addr, w_beat_m1});
          end
          if (r_cnt >= CW'(2) && r_cnt <= CW'(LINE_BEATS + 1)) begin
            w_buf_we    = 1'b1;
            w_buf_widx  = w_beat_m2;
            w_buf_wdata = ram_rdata;
          end
        end else if (r_cnt >= CW'(LINE_BEATS) && r_cnt <= CW'(2 * LINE_BEATS - 1)) begin
          // cnt 8..15: low bits equal the beat index
          ram_we     = 1'b1;
          ram_addr   = RAM_AW'({r_addr, w_beat_cur});
          w_buf_ridx = w_beat_cur;
          ram_wdata  = w_buf_rdata;
        end
        if (r_cnt == CW'(MEM_LATENCY - 1)) begin
          w_state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        bus.c2_drive = 1'b1;
        bus.c2_out   = C2_RESPONSE;
        if (r_is_write) begin
          w_state_next = ST_IDLE;
        end else begin
          w_buf_ridx = w_beat_resp;
          bus.d2_out = w_buf_rdata;
          if (r_cnt == CW'(MEM_LATENCY + LINE_BEATS - 1)) begin
            w_state_next = ST_IDLE;
          end
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. Two instances: dut1 with the
// default latency of 100 and dut2 with the minimum latency of 17. Expected
// RESPONSE beats and RAM writes are queued when a command is driven and
// compared when the DUT produces them.
module tb_mem_ctrl;
  import mem_bus_pkg::*;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] first;  // expected beat 0; beat k = first + k
  } rd_vec_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT 1 (latency 100) ----------------
  mem_bus_if #(.ADDR2_W(15), .DATA2_W(16)) bus1 ();
  logic        busy1, ram1_we;
  logic [17:0] ram1_addr;
  logic [15:0] ram1_wdata, ram1_rdata;

  mem_ctrl #(
    .ADDR2_W(15), .DATA2_W(16), .LINE_BEATS(8), .MEM_LATENCY(100), .RAM_AW(18)
  ) dut1 (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus1.slave),
    .busy      (busy1),
    .ram_addr  (ram1_addr),
    .ram_we    (ram1_we),
    .ram_wdata (ram1_wdata),
    .ram_rdata (ram1_rdata)
  );

  // ---------------- DUT 2 (latency 17) ----------------
  mem_bus_if #(.ADDR2_W(15), .DATA2_W(16)) bus2 ();
  logic        busy2, ram2_we;
  logic [17:0] ram2_addr;
  logic [15:0] ram2_wdata, ram2_rdata;

  mem_ctrl #(
    .ADDR2_W(15), .DATA2_W(16), .LINE_BEATS(8), .MEM_LATENCY(17), .RAM_AW(18)
  ) dut2 (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus2.slave),
    .busy      (busy2),
    .ram_addr  (ram2_addr),
    .ram_we    (ram2_we),
    .ram_wdata (ram2_wdata),
    .ram_rdata (ram2_rdata)
  );

  // RAM models: an unwritten word i reads back as i[15:0] (the preload)
  logic [15:0] ram1_mem [0:(1<<18)-1];
  bit          ram1_wr  [0:(1<<18)-1];
  logic [15:0] ram2_mem [0:(1<<18)-1];
  bit          ram2_wr  [0:(1<<18)-1];

  always @(posedge CLK) begin
    if (ram1_we) begin
      ram1_mem[ram1_addr] <= ram1_wdata;
      ram1_wr[ram1_addr]  <= 1'b1;
    end
    ram1_rdata <= ram1_wr[ram1_addr] ? ram1_mem[ram1_addr] : ram1_addr[15:0];
  end

  always @(posedge CLK) begin
    if (ram2_we) begin
      ram2_mem[ram2_addr] <= ram2_wdata;
      ram2_wr[ram2_addr]  <= 1'b1;
    end
    ram2_rdata <= ram2_wr[ram2_addr] ? ram2_mem[ram2_addr] : ram2_addr[15:0];
  end

  // ---------------- scoreboard ----------------
  resp_t rq1[$], rq2[$];
  wr_t   wq1[$], wq2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got 0x%0h required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: cycle %0d got activity 0x%0h, required none", name, cyc, act);
  endtask

  resp_t m1_r, m2_r;
  wr_t   m1_w, m2_w;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus1.c2_drive) begin
        if (rq1.size() == 0) unexpected("resp1_unexpected", 32'(bus1.d2_out));
        else begin
          m1_r = rq1.pop_front();
          check("resp1_cycle", cyc, m1_r.cyc);
          check("resp1_data", 32'(bus1.d2_out), 32'(m1_r.data));
          check("resp1_cmd", 32'(bus1.c2_out), 32'(C2_RESPONSE));
        end
      end else if (bus1.c2_out != C2_NOP) begin
        check("c2_out1_nop", 32'(bus1.c2_out), 32'(C2_NOP));
      end
      if (ram1_we) begin
        if (wq1.size() == 0) unexpected("ram1_we_unexpected", 32'(ram1_addr));
        else begin
          m1_w = wq1.pop_front();
          check("ram1_we_cycle", cyc, m1_w.cyc);
          check("ram1_addr", 32'(ram1_addr), 32'(m1_w.addr));
          check("ram1_wdata", 32'(ram1_wdata), 32'(m1_w.data));
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus2.c2_drive) begin
        if (rq2.size() == 0) unexpected("resp2_unexpected", 32'(bus2.d2_out));
        else begin
          m2_r = rq2.pop_front();
          check("resp2_cycle", cyc, m2_r.cyc);
          check("resp2_data", 32'(bus2.d2_out), 32'(m2_r.data));
          check("resp2_cmd", 32'(bus2.c2_out), 32'(C2_RESPONSE));
        end
      end else if (bus2.c2_out != C2_NOP) begin
        check("c2_out2_nop", 32'(bus2.c2_out), 32'(C2_NOP));
      end
      if (ram2_we) begin
        if (wq2.size() == 0) unexpected("ram2_we_unexpected", 32'(ram2_addr));
        else begin
          m2_w = wq2.pop_front();
          check("ram2_we_cycle", cyc, m2_w.cyc);
          check("ram2_addr", 32'(ram2_addr), 32'(m2_w.addr));
          check("ram2_wdata", 32'(ram2_wdata), 32'(m2_w.data));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // Drives a command for one cycle on the selected bus; returns T.
  task automatic issue(input int sel, input c2_cmd_t cmd, input logic [14:0] a,
                       input logic [15:0] d0, output int t);
    t = cyc;
    if (sel == 1) begin
      bus1.c2_in = cmd; bus1.a2_in = a; bus1.d2_in = d0;
    end else begin
      bus2.c2_in = cmd; bus2.a2_in = a; bus2.d2_in = d0;
    end
    $display("[cycle %0d] dut%0d cmd=%0d addr=0x%04h d0=0x%04h", t, sel, cmd, a, d0);
    @(negedge CLK);
    if (sel == 1) bus1.c2_in = C2_NOP;
    else          bus2.c2_in = C2_NOP;
  endtask

  // Beats 1..7 following a WRITE_LINE; called at the negedge of T+1.
  task automatic write_beats(input int sel, input logic [15:0] base);
    for (int k = 1; k < 8; k++) begin
      if (sel == 1) bus1.d2_in = base + 16'(k);
      else          bus2.d2_in = base + 16'(k);
      if (k < 7) @(negedge CLK);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_c2_out"},    32'(bus1.c2_out), 32'(C2_NOP));
    check({tag, "_d2_out"},    32'(bus1.d2_out), 32'h0);
    check({tag, "_c2_drive"},  32'(bus1.c2_drive), 32'h0);
    check({tag, "_busy"},      32'(busy1), 32'h0);
    check({tag, "_ram_we"},    32'(ram1_we), 32'h0);
    check({tag, "_ram_addr"},  32'(ram1_addr), 32'h0);
    check({tag, "_ram_wdata"}, 32'(ram1_wdata), 32'h0);
  endtask

  // ---------------- main sequence ----------------
  rd_vec_t tbl[4];
  int t, t2;

  initial begin
    tbl[0] = '{addr: 15'h0005, first: 16'h0028};
    tbl[1] = '{addr: 15'h0000, first: 16'h0000};
    tbl[2] = '{addr: 15'h0100, first: 16'h0800};
    tbl[3] = '{addr: 15'h1234, first: 16'h91A0};

    bus1.c2_in = C2_NOP; bus1.a2_in = '0; bus1.d2_in = '0;
    bus2.c2_in = C2_NOP; bus2.a2_in = '0; bus2.d2_in = '0;

    // Power-on reset
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    check("por_busy2", 32'(busy2), 32'h0);
    RESET = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);

    // Reset during an active read: no RESPONSE may follow
    issue(1, C2_READ_LINE, 15'h0020, 16'h0, t);
    check("rst_busy_active", 32'(busy1), 32'h1);
    wait_until(t + 40);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midrst");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    wait_until(t + 121);
    check("rst_busy_after", 32'(busy1), 32'h0);

    // Table-driven reads
    for (int i = 0; i < 4; i++) begin
      issue(1, C2_READ_LINE, tbl[i].addr, 16'h0, t);
      for (int k = 0; k < 8; k++) rq1.push_back('{cyc: t + 100 + k, data: tbl[i].first + 16'(k)});
      check("rd_busy_t1", 32'(busy1), 32'h1);
      wait_until(t + 107);
      check("rd_busy_last", 32'(busy1), 32'h1);
      @(negedge CLK);
      check("rd_idle_t108", 32'(busy1), 32'h0);
      check("rd_q_drained", rq1.size(), 0);
    end

    // Write 0x7FFF then read it back
    issue(1, C2_WRITE_LINE, 15'h7FFF, 16'hA000, t);
    for (int k = 0; k < 8; k++) wq1.push_back('{cyc: t + 8 + k, addr: 18'h3FFF8 + 18'(k), data: 16'hA000 + 16'(k)});
    rq1.push_back('{cyc: t + 100, data: 16'h0000});
    write_beats(1, 16'hA000);
    wait_until(t + 101);
    check("wr_idle_t101", 32'(busy1), 32'h0);
    check("wr_q_drained", wq1.size(), 0);
    issue(1, C2_READ_LINE, 15'h7FFF, 16'h0, t2);
    for (int k = 0; k < 8; k++) rq1.push_back('{cyc: t2 + 100 + k, data: 16'hA000 + 16'(k)});
    wait_until(t2 + 108);
    check("wrrd_idle", 32'(busy1), 32'h0);

    // Command while busy is dropped
    issue(1, C2_READ_LINE, 15'h0010, 16'h0, t);
    for (int k = 0; k < 8; k++) rq1.push_back('{cyc: t + 100 + k, data: 16'h0080 + 16'(k)});
    wait_until(t + 50);
    issue(1, C2_WRITE_LINE, 15'h0011, 16'hDEAD, t2);
    write_beats(1, 16'hDEAD);
    wait_until(t + 108);
    check("drop_idle", 32'(busy1), 32'h0);
    repeat (10) @(negedge CLK);
    check("drop_busy_stays_low", 32'(busy1), 32'h0);

    // Minimum latency instance: write, then read in the first IDLE cycle
    issue(2, C2_WRITE_LINE, 15'h0003, 16'hB000, t);
    for (int k = 0; k < 8; k++) wq2.push_back('{cyc: t + 8 + k, addr: 18'h00018 + 18'(k), data: 16'hB000 + 16'(k)});
    rq2.push_back('{cyc: t + 17, data: 16'h0000});
    write_beats(2, 16'hB000);
    wait_until(t + 18);
    check("min_idle_t18", 32'(busy2), 32'h0);
    issue(2, C2_READ_LINE, 15'h0003, 16'h0, t2);
    for (int k = 0; k < 8; k++) rq2.push_back('{cyc: t2 + 17 + k, data: 16'hB000 + 16'(k)});
    wait_until(t2 + 25);
    check("min_idle_end", 32'(busy2), 32'h0);

    repeat (5) @(negedge CLK);
    check("end_rq1_empty", rq1.size(), 0);
    check("end_wq1_empty", wq1.size(), 0);
    check("end_rq2_empty", rq2.size(), 0);
    check("end_wq2_empty", wq2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
